// File: rtl/count_down_screen_gen.sv
// Countdown-screen controller: steps a count from COUNT_FROM to 0, exchanges held emoji
// with the peer board and renders a registered 16-glyph LCD frame.
module count_down_screen_gen #(
    parameter int TICK_DIV   = 100,
    parameter int COUNT_FROM = 3,
    parameter int HOLD_TICKS = 2,
    parameter int N_EMO      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         pause,
    input  logic [3:0]   key,
    input  logic         key_valid,
    input  logic [3:0]   dialogue_in,
    input  logic [2:0]   game_sel,
    output logic [6:0]   count,
    output logic         busy,
    output logic         done,
    output logic [3:0]   dialogue_out,
    output logic [127:0] data_out
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [6:0]        COUNT_INIT = 7'(COUNT_FROM);
    localparam logic [3:0]        EMO_NONE   = 4'(N_EMO);

    // Glyph codes: ASCII for text, upper-half digit set for the big-digit bottom row,
    // and custom character slots 0..7 for the emoji graphics.
    localparam logic [7:0] FONT_NONE    = 8'h20;
    localparam logic [7:0] DIGIT_TOP    = 8'h30;
    localparam logic [7:0] DIGIT_BOT    = 8'hB0;
    localparam logic [7:0] GRAPH_SMILE  = 8'h00;
    localparam logic [7:0] GRAPH_ANGRY  = 8'h01;
    localparam logic [7:0] GRAPH_SLEEPY = 8'h02;
    localparam logic [7:0] GRAPH_SHINE  = 8'h03;
    localparam logic [7:0] GRAPH_LOVE   = 8'h04;
    localparam logic [7:0] GRAPH_SAD    = 8'h05;
    localparam logic [7:0] GRAPH_LIKE   = 8'h06;
    localparam logic [7:0] GRAPH_FUCK   = 8'h07;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [6:0]         count_reg, count_next;
    logic               tick;
    logic               busy_reg, done_reg;

    logic [3:0]         key_idx;
    logic               key_mapped, key_hit;
    logic [3:0]         dlg_reg;
    logic [HOLD_W-1:0]  loc_hold_reg;

    logic [3:0]         sync1_reg, sync2_reg, rem_emo_reg;
    logic [HOLD_W-1:0]  rem_hold_reg;

    logic [6:0]         tens, ones;
    logic [31:0]        banner;
    logic [7:0]         glyph [16];
    logic [127:0]       frame_next, data_out_reg;

    function automatic logic [7:0] emo_glyph(input logic [3:0] code);
        case (code)
            4'd0:    return GRAPH_SMILE;
            4'd1:    return GRAPH_ANGRY;
            4'd2:    return GRAPH_SLEEPY;
            4'd3:    return GRAPH_SHINE;
            4'd4:    return GRAPH_LOVE;
            4'd5:    return GRAPH_SAD;
            4'd6:    return GRAPH_LIKE;
            4'd7:    return GRAPH_FUCK;
            default: return FONT_NONE;
        endcase
    endfunction

    // start has priority over a coincident tick, so a restart never produces done.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        count_next = count_reg;
        tick       = 1'b0;
        if (start) begin
            state_next = S_COUNT;
            div_next   = '0;
            count_next = COUNT_INIT;
        end else if (state_reg == S_COUNT && !pause) begin
            if (div_reg == DIV_LAST) begin
                div_next   = '0;
                tick       = 1'b1;
                count_next = count_reg - 7'd1;
                if (count_reg == 7'd1) begin
                    state_next = S_DONE;
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    // busy lags the state by one cycle; done fires in the first cycle after DONE is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            div_reg   <= '0;
            count_reg <= COUNT_INIT;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            count_reg <= count_next;
            busy_reg  <= (state_reg == S_COUNT);
            done_reg  <= (state_reg == S_DONE) && busy_reg;
        end
    end

    always_comb begin
        key_idx    = 4'd0;
        key_mapped = 1'b1;
        case (key)
            4'hA:    key_idx = 4'd0;
            4'h2:    key_idx = 4'd1;
            4'h5:    key_idx = 4'd2;
            4'h8:    key_idx = 4'd3;
            4'h0:    key_idx = 4'd4;
            4'h1:    key_idx = 4'd5;
            4'h4:    key_idx = 4'd6;
            4'h7:    key_idx = 4'd7;
            default: key_mapped = 1'b0;
        endcase
        key_hit = key_valid && key_mapped && (key_idx < EMO_NONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dlg_reg      <= EMO_NONE;
            loc_hold_reg <= '0;
        end else if (key_hit) begin
            dlg_reg      <= key_idx;
            loc_hold_reg <= HOLD_INIT;
        end else if (tick && loc_hold_reg != '0) begin
            loc_hold_reg <= loc_hold_reg - HOLD_ONE;
            if (loc_hold_reg == HOLD_ONE) begin
                dlg_reg <= EMO_NONE;
            end
        end
    end

    // The change is detected on the value about to enter sync2, so the remote emoji
    // latches on the same edge the synchroniser output updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg    <= EMO_NONE;
            sync2_reg    <= EMO_NONE;
            rem_emo_reg  <= EMO_NONE;
            rem_hold_reg <= '0;
        end else begin
            sync1_reg <= dialogue_in;
            sync2_reg <= sync1_reg;
            if (sync1_reg != sync2_reg && sync1_reg < EMO_NONE) begin
                rem_emo_reg  <= sync1_reg;
                rem_hold_reg <= HOLD_INIT;
            end else if (tick && rem_hold_reg != '0) begin
                rem_hold_reg <= rem_hold_reg - HOLD_ONE;
                if (rem_hold_reg == HOLD_ONE) begin
                    rem_emo_reg <= EMO_NONE;
                end
            end
        end
    end

    always_comb begin
        tens = count_reg / 7'd10;
        ones = count_reg % 7'd10;
        case (game_sel)
            3'd0:    banner = "FLCK";
            3'd1:    banner = "MORA";
            3'd2:    banner = "H/L ";
            3'd3:    banner = "RAIN";
            default: banner = {4{FONT_NONE}};
        endcase
        for (int i = 0; i < 16; i++) begin
            glyph[i] = FONT_NONE;
        end
        glyph[5]  = (tens == 7'd0) ? FONT_NONE : DIGIT_TOP + {1'b0, tens};
        glyph[6]  = DIGIT_TOP + {1'b0, ones};
        glyph[8]  = emo_glyph(dlg_reg);
        glyph[9]  = (tens == 7'd0) ? FONT_NONE : DIGIT_BOT + {1'b0, tens};
        glyph[10] = DIGIT_BOT + {1'b0, ones};
        glyph[11] = emo_glyph(rem_emo_reg);
        for (int i = 0; i < 4; i++) begin
            glyph[12 + i] = banner[31 - 8*i -: 8];
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign frame_next[127 - 8*gi -: 8] = glyph[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_reg <= {16{FONT_NONE}};
        end else begin
            data_out_reg <= frame_next;
        end
    end

    assign count        = count_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign dialogue_out = dlg_reg;
    assign data_out     = data_out_reg;

endmodule
